// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl
// Transaction controller for the vending datapath. Credit is counted in
// 0.5-unit steps. A selection with enough credit runs a dispenser handshake.
// Leftover credit is then paid back as 0.5 coins, one per hopper handshake.
// Cancel returns the full credit the same way.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   coin[1:0]  in   1-cycle coin pulse, [0]=0.5 (value 1), [1]=1.0 (value 2)
//   sel[1:0]   in   1-cycle select pulse, [0]=item A, [1]=item B
//   cancel     in   1-cycle refund request
//   disp_ack   in   dispenser finished
//   chg_ack    in   hopper emitted one 0.5 coin
//   disp_req   out  dispense request, held until disp_ack
//   disp_item  out  0=A, 1=B, valid while disp_req
//   chg_req    out  change request while credit remains in CHANGE
//   credit     out  current credit in 0.5 units
//   busy       out  high in DISP or CHANGE
//   err_low    out  1-cycle pulse, selection with too little credit
//   coin_rej   out  1-cycle pulse, coin not accepted
//   timeout    out  1-cycle pulse, auto-refund started
//
// Optional feature
//   TIMEOUT_REFUND_EN: when defined, ACCUM refunds the credit after
//   TIMEOUT_CYC idle cycles. When undefined, there is no timer and the
//   timeout output stays 0.
// ---------------------------------------------------------------------------
module vend_ctrl #(
    parameter int CREDIT_W    = 5,
    parameter int PRICE_A     = 4,
    parameter int PRICE_B     = 5,
    parameter int MAX_CREDIT  = 20,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ack,
    output logic                disp_req,
    output logic                disp_item,
    output logic                chg_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                err_low,
    output logic                coin_rej,
    output logic                timeout
);

    typedef enum logic [1:0] {IDLE, ACCUM, DISP, CHANGE} state_e;

    localparam logic [CREDIT_W-1:0] PriceA    = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PriceB    = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W:0]   MaxCredit = (CREDIT_W+1)'(MAX_CREDIT);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_req_q, disp_req_d;
    logic                disp_item_q, disp_item_d;
    logic                chg_req_q, chg_req_d;
    logic                busy_q, busy_d;
    logic                err_low_q, err_low_d;
    logic                coin_rej_q, coin_rej_d;
    logic                timeout_q, timeout_d;

    logic                coin_ev;
    logic                sel_ev;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] price;

`ifdef TIMEOUT_REFUND_EN
    localparam int              TimerW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);
    logic [TimerW-1:0] timer_q, timer_d;
    logic              expired;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Decode the input pulses. The 0.5 coin and item A win when both bits
    // are set. The sum is one bit wider so the ceiling test cannot be
    // fooled by wrap-around.
    always_comb begin
        coin_ev  = |coin;
        sel_ev   = |sel;
        coin_val = '0;
        if (coin[0]) begin
            coin_val = (CREDIT_W+1)'(1);
        end else if (coin[1]) begin
            coin_val = (CREDIT_W+1)'(2);
        end
        credit_sum = {1'b0, credit_q} + coin_val;
        price      = sel[0] ? PriceA : PriceB;
    end

`ifdef TIMEOUT_REFUND_EN
    // The idle timer only runs while ACCUM sees no coin, sel or cancel.
    // It restarts on entry to ACCUM and on every event. A coin on the expiry
    // cycle is an event, so it wins over the timeout.
    always_comb begin
        expired = (timer_q == TimerMax);
        timer_d = '0;
        if (state_q == ACCUM && state_d == ACCUM && !(coin_ev || sel_ev || cancel)) begin
            timer_d = timer_q + TimerW'(1);
        end
    end
`endif

    // Next-state and next-output logic. Every output is registered, so
    // each *_d value is what the outputs will show after this edge.
    // Inside ACCUM, cancel has priority over sel, and sel over coin.
    // A coin that arrives together with cancel or sel is rejected.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        disp_item_d = disp_item_q;
        err_low_d   = 1'b0;
        coin_rej_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_ev) begin
                    credit_d = coin_val[CREDIT_W-1:0];
                    state_d  = ACCUM;
                end
                if (sel_ev) begin
                    err_low_d = 1'b1;
                end
            end
            ACCUM: begin
                if (cancel) begin
                    state_d    = CHANGE;
                    coin_rej_d = coin_ev;
                end else if (sel_ev) begin
                    coin_rej_d = coin_ev;
                    if (credit_q >= price) begin
                        credit_d    = credit_q - price;
                        disp_item_d = ~sel[0];
                        state_d     = DISP;
                    end else begin
                        err_low_d = 1'b1;
                    end
                end else if (coin_ev) begin
                    if (credit_sum <= MaxCredit) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                    end else begin
                        coin_rej_d = 1'b1;
                    end
`ifdef TIMEOUT_REFUND_EN
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = CHANGE;
`endif
                end
            end
            DISP: begin
                coin_rej_d = coin_ev;
                if (disp_ack) begin
                    disp_item_d = 1'b0;
                    state_d     = (credit_q == '0) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                coin_rej_d = coin_ev;
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (chg_ack && chg_req_q) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        disp_req_d = (state_d == DISP);
        chg_req_d  = (state_d == CHANGE) && (credit_d != '0);
        busy_d     = (state_d == DISP) || (state_d == CHANGE);
    end

    // State and output registers. Reset drops any transaction in flight
    // and discards the credit without a refund.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            disp_req_q  <= 1'b0;
            disp_item_q <= 1'b0;
            chg_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_low_q   <= 1'b0;
            coin_rej_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            disp_req_q  <= disp_req_d;
            disp_item_q <= disp_item_d;
            chg_req_q   <= chg_req_d;
            busy_q      <= busy_d;
            err_low_q   <= err_low_d;
            coin_rej_q  <= coin_rej_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef TIMEOUT_REFUND_EN
    // Idle timer register. It is cleared with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign disp_req  = disp_req_q;
    assign disp_item = disp_item_q;
    assign chg_req   = chg_req_q;
    assign credit    = credit_q;
    assign busy      = busy_q;
    assign err_low   = err_low_q;
    assign coin_rej  = coin_rej_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl
// Directed scoreboard bench for vend_ctrl. Each stimulus step names the
// output vector expected after its clock edge. Only changes are queued,
// each tagged with the cycle in which it must appear. A monitor watches the
// outputs on the falling edge. Whenever they change, it pops the next
// expectation and compares both the value and the cycle.
// ---------------------------------------------------------------------------
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;
    logic       disp_req;
    logic       disp_item;
    logic       chg_req;
    logic [4:0] credit;
    logic       busy;
    logic       err_low;
    logic       coin_rej;
    logic       timeout;

    typedef struct {
        int          cyc;
        logic [11:0] vec;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    logic [11:0] lastExp = 'x;
    logic [11:0] prevVec = 'x;
    logic [11:0] curVec;
    int          cycleCount = 0;
    int          checks = 0;
    int          failures = 0;
    string       phase = "reset";

    vend_ctrl #(
        .CREDIT_W   (5),
        .PRICE_A    (4),
        .PRICE_B    (5),
        .MAX_CREDIT (20),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .coin     (coin),
        .sel      (sel),
        .cancel   (cancel),
        .disp_ack (disp_ack),
        .chg_ack  (chg_ack),
        .disp_req (disp_req),
        .disp_item(disp_item),
        .chg_req  (chg_req),
        .credit   (credit),
        .busy     (busy),
        .err_low  (err_low),
        .coin_rej (coin_rej),
        .timeout  (timeout)
    );

    // Free-running clock and edge counter, used to time-stamp expectations
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount = cycleCount + 1;

    // Pack an expected output vector as {disp_req, disp_item, chg_req, credit, busy, err_low, coin_rej, timeout}
    function automatic logic [11:0] v(input int cr, input bit dr, input bit di, input bit ch,
                                      input bit b, input bit el, input bit cj, input bit to);
        logic [4:0] crb;
        crb = cr[4:0];
        return {dr, di, ch, crb, b, el, cj, to};
    endfunction

    function automatic logic [11:0] vI(input int cr);
        return v(cr, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [11:0] vC(input int cr);
        return v(cr, 0, 0, 1, 1, 0, 0, 0);
    endfunction

    // Queue an expectation for the edge that follows, but only if it differs from the previous one
    task automatic expectAfterEdge(input logic [11:0] e);
        exp_t x;
        if (e !== lastExp) begin
            x.cyc  = cycleCount + 1;
            x.vec  = e;
            x.name = phase;
            expQ.push_back(x);
        end
        lastExp = e;
    endtask

    // Drive one cycle of inputs and record what the outputs should be after the edge
    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic [1:0] s,
                                 input logic cn, input logic da, input logic ca,
                                 input logic [11:0] e);
        @(negedge clk);
        rst      = r;
        coin     = c;
        sel      = s;
        cancel   = cn;
        disp_ack = da;
        chg_ack  = ca;
        expectAfterEdge(e);
    endtask

    task automatic idle(input logic [11:0] e);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, e);
    endtask

    // Compare one observed output change against the head of the scoreboard
    task automatic checkOutput(input logic [11:0] got);
        exp_t e;
        checks = checks + 1;
        if (expQ.size() == 0) begin
            failures = failures + 1;
            $display("[TB] FAIL unexpected_change: got vec=%h at cycle %0d, required no change", got, cycleCount);
        end else begin
            e = expQ.pop_front();
            if (got !== e.vec || cycleCount != e.cyc) begin
                failures = failures + 1;
                $display("[TB] FAIL %s: got vec=%h at cycle %0d, required vec=%h at cycle %0d",
                         e.name, got, cycleCount, e.vec, e.cyc);
            end
        end
    endtask

    // Monitor: any change on the outputs is a DUT event to be checked
    always @(negedge clk) begin
        curVec = {disp_req, disp_item, chg_req, credit, busy, err_low, coin_rej, timeout};
        if (curVec !== prevVec) begin
            checkOutput(curVec);
            prevVec = curVec;
        end
    end

    // Directed stimulus
    initial begin
        exp_t left;
        rst = 1'b1; coin = '0; sel = '0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
        expectAfterEdge(vI(0));
        applyStimulus(1, 0, 0, 0, 0, 0, vI(0));

        phase = "buy_a_exact";
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(2));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(4));
        applyStimulus(0, 0, 2'b01, 0, 0, 0, v(0, 1, 0, 0, 1, 0, 0, 0));
        idle(v(0, 1, 0, 0, 1, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 1, 0, vI(0));
        idle(vI(0));

        phase = "buy_b_change";
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(2));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(4));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(6));
        applyStimulus(0, 0, 2'b10, 0, 0, 0, v(1, 1, 1, 0, 1, 0, 0, 0));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, v(1, 1, 1, 0, 1, 0, 1, 0));
        idle(v(1, 1, 1, 0, 1, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 1, 0, vC(1));
        idle(vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

        phase = "low_credit_cancel";
        applyStimulus(0, 0, 2'b01, 0, 0, 0, v(0, 0, 0, 0, 0, 1, 0, 0));
        idle(vI(0));
        applyStimulus(0, 0, 0, 1, 0, 0, vI(0));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        applyStimulus(0, 0, 2'b01, 0, 0, 0, v(1, 0, 0, 0, 0, 1, 0, 0));
        applyStimulus(0, 0, 0, 1, 0, 0, vC(1));
        idle(vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

        phase = "ceiling_20";
        for (int i = 1; i <= 10; i++) applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(2 * i));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, v(20, 0, 0, 0, 0, 0, 1, 0));
        idle(vI(20));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, v(20, 0, 0, 0, 0, 0, 1, 0));
        idle(vI(20));
        applyStimulus(0, 0, 0, 1, 0, 0, vC(20));
        for (int k = 19; k >= 1; k--) applyStimulus(0, 0, 0, 0, 0, 1, vC(k));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

        phase = "ceiling_19";
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        for (int i = 1; i <= 9; i++) applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(1 + 2 * i));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, v(19, 0, 0, 0, 0, 0, 1, 0));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(20));
        applyStimulus(0, 2'b01, 0, 1, 0, 0, v(20, 0, 0, 1, 1, 0, 1, 0));
        for (int k = 19; k >= 1; k--) applyStimulus(0, 0, 0, 0, 0, 1, vC(k));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

        phase = "coin_with_sel";
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(2));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(4));
        applyStimulus(0, 2'b10, 2'b01, 0, 0, 0, v(0, 1, 0, 0, 1, 0, 1, 0));
        idle(v(0, 1, 0, 0, 1, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 1, 0, vI(0));

        phase = "reset_in_change";
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(2));
        applyStimulus(0, 2'b10, 0, 0, 0, 0, vI(4));
        applyStimulus(0, 0, 0, 1, 0, 0, vC(4));
        applyStimulus(0, 0, 0, 0, 0, 1, vC(3));
        applyStimulus(1, 0, 0, 0, 0, 0, vI(0));
        idle(vI(0));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        applyStimulus(0, 0, 0, 1, 0, 0, vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

`ifdef TIMEOUT_REFUND_EN
        phase = "timeout";
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        repeat (7) idle(vI(1));
        idle(v(1, 0, 0, 1, 1, 0, 0, 1));
        idle(vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));

        phase = "coin_on_expiry";
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        repeat (7) idle(vI(1));
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(2));
        repeat (7) idle(vI(2));
        idle(v(2, 0, 0, 1, 1, 0, 0, 1));
        applyStimulus(0, 0, 0, 0, 0, 1, vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));
`else
        phase = "no_timeout";
        applyStimulus(0, 2'b01, 0, 0, 0, 0, vI(1));
        repeat (12) idle(vI(1));
        applyStimulus(0, 0, 0, 1, 0, 0, vC(1));
        applyStimulus(0, 0, 0, 0, 0, 1, vI(0));
`endif

        phase = "drain";
        repeat (3) idle(vI(0));
        @(negedge clk);
        @(negedge clk);
        while (expQ.size() > 0) begin
            left = expQ.pop_front();
            checks = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL %s: got no change, required vec=%h at cycle %0d", left.name, left.vec, left.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
